// File: rtl/perf_event_counters.sv
// Performance-event counters with IDLE/RUN/HALTED control and a registered read port.
// Build option PERF_OVF_STATUS_EN: counters wrap with sticky overflow flags; otherwise they saturate.
//
//  state  | meaning
//  IDLE   | counters hold, waiting for start
//  RUN    | events accumulate every cycle, including the halt cycle
//  HALTED | counters frozen after the retiring halt; only clr leaves
module perf_event_counters #(
    parameter int CNT_W   = 32,
    parameter int NUM_CNT = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr,
    input  logic             halt,
    input  logic             reg_write,
    input  logic             mem_write,
    input  logic             icache_req,
    input  logic             icache_hit,
    input  logic             dcache_req,
    input  logic             dcache_hit,
    input  logic             rd_en,
    input  logic [2:0]       rd_sel,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             running,
    output logic             halted,
    output logic             proto_err,
    output logic             ovf_irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt [NUM_CNT];
    logic [5:0]       evt;
    logic [CNT_W-1:0] rdMux;
    logic             hitNoReq;
`ifdef PERF_OVF_STATUS_EN
    logic [NUM_CNT-1:0] ovf;
`endif

    always_comb begin
        evt      = 6'b0;
        evt[0]   = 1'b1;
        evt[1]   = halt | reg_write | mem_write;
        evt[2]   = icache_req;
        evt[3]   = icache_hit;
        evt[4]   = dcache_req;
        evt[5]   = dcache_hit;
        hitNoReq = (icache_hit & ~icache_req) | (dcache_hit & ~dcache_req);
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        rdMux = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel == 3'(i)) rdMux = cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
`ifdef PERF_OVF_STATUS_EN
            ovf       <= '0;
`endif
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rdMux;

            if (clr) begin
                state     <= IDLE;
                proto_err <= 1'b0;
                for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
`ifdef PERF_OVF_STATUS_EN
                ovf       <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start) state <= RUN;
                    end
                    RUN: begin
                        for (int i = 0; i < NUM_CNT; i++) begin
                            if (evt[i]) begin
`ifdef PERF_OVF_STATUS_EN
                                if (&cnt[i]) ovf[i] <= 1'b1;
                                cnt[i] <= cnt[i] + 1'b1;
`else
                                if (!(&cnt[i])) cnt[i] <= cnt[i] + 1'b1;
`endif
                            end
                        end
                        if (hitNoReq) proto_err <= 1'b1;
                        if (halt) state <= HALTED;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign running = (state == RUN);
    assign halted  = (state == HALTED);

`ifdef PERF_OVF_STATUS_EN
    assign ovf_irq = |ovf;
`else
    assign ovf_irq = 1'b0;
`endif

endmodule

// File: tb/tb_perf_event_counters.sv
// Bench for perf_event_counters: a 32-bit and a 4-bit instance share stimulus and are
// compared each cycle against an unbounded-count reference model.
module tb_perf_event_counters;

    logic clk = 1'b0;
    logic rst, start, clr, halt, reg_write, mem_write;
    logic icache_req, icache_hit, dcache_req, dcache_hit, rd_en;
    logic [2:0] rd_sel;

    logic        rdValid32, running32, halted32, protoErr32, ovfIrq32;
    logic [31:0] rdData32;
    logic        rdValid4, running4, halted4, protoErr4, ovfIrq4;
    logic [3:0]  rdData4;

    int passCnt  = 0;
    int totalCnt = 0;

    // Reference model: true (unbounded) event counts, mapped to each width on compare.
    int     mState;        // 0 idle, 1 run, 2 halted
    longint mCnt [6];
    bit     mProto, mRdValid;
    longint mRdTrue;

    always #5 clk = ~clk;

    perf_event_counters #(.CNT_W(32), .NUM_CNT(6)) dut32 (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .halt(halt),
        .reg_write(reg_write), .mem_write(mem_write),
        .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_valid(rdValid32), .rd_data(rdData32),
        .running(running32), .halted(halted32), .proto_err(protoErr32), .ovf_irq(ovfIrq32)
    );

    perf_event_counters #(.CNT_W(4), .NUM_CNT(6)) dut4 (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .halt(halt),
        .reg_write(reg_write), .mem_write(mem_write),
        .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_valid(rdValid4), .rd_data(rdData4),
        .running(running4), .halted(halted4), .proto_err(protoErr4), .ovf_irq(ovfIrq4)
    );

    function automatic longint disp(input longint t, input int w);
        longint lim = longint'(1) << w;
`ifdef PERF_OVF_STATUS_EN
        return t % lim;
`else
        return (t >= lim) ? lim - 1 : t;
`endif
    endfunction

    function automatic bit expOvf(input int w);
`ifdef PERF_OVF_STATUS_EN
        for (int i = 0; i < 6; i++) if (mCnt[i] >= (longint'(1) << w)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic modelStep();
        if (!rst) begin
            mState = 0; mProto = 0; mRdValid = 0; mRdTrue = 0;
            for (int i = 0; i < 6; i++) mCnt[i] = 0;
            return;
        end
        mRdValid = rd_en;
        if (rd_en) mRdTrue = (int'(rd_sel) < 6) ? mCnt[int'(rd_sel)] : 0;
        if (clr) begin
            mState = 0; mProto = 0;
            for (int i = 0; i < 6; i++) mCnt[i] = 0;
        end else if (mState == 0) begin
            if (start) mState = 1;
        end else if (mState == 1) begin
            mCnt[0]++;
            if (halt || reg_write || mem_write) mCnt[1]++;
            if (icache_req) mCnt[2]++;
            if (icache_hit) mCnt[3]++;
            if (dcache_req) mCnt[4]++;
            if (dcache_hit) mCnt[5]++;
            if ((icache_hit && !icache_req) || (dcache_hit && !dcache_req)) mProto = 1;
            if (halt) mState = 2;
        end
    endtask

    task automatic cycle();
        modelStep();
        @(posedge clk);
        #1;
        chk("running32", running32, mState == 1);
        chk("halted32", halted32, mState == 2);
        chk("proto32", protoErr32, mProto);
        chk("rdvalid32", rdValid32, mRdValid);
        chk("rddata32", rdData32, disp(mRdTrue, 32));
        chk("ovf32", ovfIrq32, expOvf(32));
        chk("running4", running4, mState == 1);
        chk("halted4", halted4, mState == 2);
        chk("proto4", protoErr4, mProto);
        chk("rdvalid4", rdValid4, mRdValid);
        chk("rddata4", rdData4, disp(mRdTrue, 4));
        chk("ovf4", ovfIrq4, expOvf(4));
    endtask

    task automatic readBack(input logic [2:0] s);
        rd_en = 1'b1; rd_sel = s;
        cycle();
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 0; start = 0; clr = 0; halt = 0; reg_write = 0; mem_write = 0;
        icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
        rd_en = 0; rd_sel = 3'd0;
        cycle();
        cycle();
        chk("reset rd_valid", rdValid32, 1'b0);
        chk("reset rd_data", rdData32, 32'd0);
        chk("reset running", running32, 1'b0);

        // T1: 10 RUN cycles, reg_write on 4 of them, then halt
        rst = 1; start = 1;
        cycle();
        start = 0;
        for (int i = 0; i < 10; i++) begin
            reg_write = (i % 3 == 0);
            cycle();
        end
        reg_write = 0; halt = 1;
        cycle();
        halt = 0;
        chk("T1 halted", halted32, 1'b1);
        chk("T1 running", running32, 1'b0);
        readBack(3'd0);
        chk("T1 cnt0", rdData32, 32'd11);
        readBack(3'd1);
        chk("T1 cnt1", rdData32, 32'd5);

        // T2: events and start after halt are ignored
        reg_write = 1; icache_req = 1;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            cycle();
        end
        reg_write = 0; icache_req = 0; start = 0;
        readBack(3'd0);
        chk("T2 cnt0", rdData32, 32'd11);
        chk("T2 rd_valid", rdValid32, 1'b1);
        cycle();
        chk("T2 rd_valid drop", rdValid32, 1'b0);
        chk("T2 rd_data hold", rdData32, 32'd11);

        // T3: icache hits, one without request
        clr = 1; cycle(); clr = 0;
        start = 1; cycle(); start = 0;
        icache_req = 1; icache_hit = 1;
        repeat (3) cycle();
        icache_req = 0;
        cycle();
        icache_hit = 0;
        readBack(3'd2);
        chk("T3 cnt2", rdData32, 32'd3);
        readBack(3'd3);
        chk("T3 cnt3", rdData32, 32'd4);
        chk("T3 proto", protoErr32, 1'b1);

        // T4: clr beats a simultaneous dcache_req
        dcache_req = 1;
        repeat (2) cycle();
        clr = 1;
        cycle();
        clr = 0; dcache_req = 0;
        chk("T4 running", running32, 1'b0);
        chk("T4 proto", protoErr32, 1'b0);
        readBack(3'd4);
        chk("T4 cnt4 cleared", rdData32, 32'd0);
        start = 1; cycle(); start = 0;
        dcache_req = 1;
        repeat (2) cycle();
        dcache_req = 0;
        readBack(3'd4);
        chk("T4 cnt4 resumed", rdData32, 32'd2);

        // T5: 16 RUN cycles on the 4-bit instance
        clr = 1; cycle(); clr = 0;
        start = 1; cycle(); start = 0;
        repeat (16) cycle();
`ifdef PERF_OVF_STATUS_EN
        chk("T5 ovf_irq", ovfIrq4, 1'b1);
        readBack(3'd0);
        chk("T5 cnt0 w4", rdData4, 4'd0);
`else
        chk("T5 ovf_irq", ovfIrq4, 1'b0);
        readBack(3'd0);
        chk("T5 cnt0 w4", rdData4, 4'd15);
`endif
        chk("T5 cnt0 w32", rdData32, 32'd16);

        // T6: reset mid-RUN with a read in flight
        rst = 0; rd_en = 1; rd_sel = 3'd0;
        cycle();
        rd_en = 0; rst = 1;
        chk("T6 rd_valid", rdValid32, 1'b0);
        chk("T6 running", running32, 1'b0);
        chk("T6 rd_data", rdData32, 32'd0);
        readBack(3'd7);
        chk("T6 sel7 valid", rdValid32, 1'b1);
        chk("T6 sel7 data", rdData32, 32'd0);
        readBack(3'd0);
        chk("T6 cnt0", rdData32, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) != 0);
            start      = ($urandom_range(0, 19) == 0);
            clr        = ($urandom_range(0, 79) == 0);
            halt       = ($urandom_range(0, 39) == 0);
            reg_write  = $urandom_range(0, 1) != 0;
            mem_write  = $urandom_range(0, 1) != 0;
            icache_req = $urandom_range(0, 1) != 0;
            icache_hit = $urandom_range(0, 1) != 0;
            dcache_req = $urandom_range(0, 1) != 0;
            dcache_hit = $urandom_range(0, 1) != 0;
            rd_en      = $urandom_range(0, 1) != 0;
            rd_sel     = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
